// File: rtl/fifo_ctrl.sv
// fifo_ctrl: push/pop FIFO controller for a dual-port synchronous RAM with a
// registered (1-cycle latency) read port. Owns the pointers, occupancy count,
// status flags and sticky error flags. The RAM itself lives beside this block.
//
// Ports
//   clk, reset        clock (rising edge), synchronous active-low reset
//   push, data_push   write request and data
//   pop               read request
//   pop_data          read data, qualified by pop_valid (one cycle after pop)
//   full, empty       count == RAM_DEPTH, count == 0 (registered)
//   almost_full       count >= ALMOST_FULL_TH (registered)
//   almost_empty      count <= ALMOST_EMPTY_TH (registered)
//   count             current occupancy
//   err_overflow      sticky, a push was rejected
//   err_underflow     sticky, a pop was rejected
//   wr_enb, wr_addr, data_in   RAM write port drive
//   rd_enb, rd_addr            RAM read port drive
//   data_out          registered read data from the RAM
module fifo_ctrl #(
  parameter int unsigned RAM_WIDTH       = 8,
  parameter int unsigned ADDER_SIZE      = 3,
  parameter int unsigned RAM_DEPTH       = 8,
  parameter int unsigned ALMOST_FULL_TH  = 6,
  parameter int unsigned ALMOST_EMPTY_TH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [RAM_WIDTH-1:0]  data_push,
  input  logic                  pop,
  output logic [RAM_WIDTH-1:0]  pop_data,
  output logic                  pop_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDER_SIZE:0]   count,
  output logic                  err_overflow,
  output logic                  err_underflow,
  output logic                  wr_enb,
  output logic [ADDER_SIZE-1:0] wr_addr,
  output logic [RAM_WIDTH-1:0]  data_in,
  output logic                  rd_enb,
  output logic [ADDER_SIZE-1:0] rd_addr,
  input  logic [RAM_WIDTH-1:0]  data_out
);

  localparam logic [ADDER_SIZE:0]   DepthCnt = (ADDER_SIZE+1)'(RAM_DEPTH);
  localparam logic [ADDER_SIZE:0]   AfullTh  = (ADDER_SIZE+1)'(ALMOST_FULL_TH);
  localparam logic [ADDER_SIZE:0]   AemptyTh = (ADDER_SIZE+1)'(ALMOST_EMPTY_TH);
  localparam logic [ADDER_SIZE:0]   CntOne   = (ADDER_SIZE+1)'(1);
  localparam logic [ADDER_SIZE-1:0] PtrOne   = ADDER_SIZE'(1);

  logic [ADDER_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDER_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDER_SIZE:0]   count_q, count_d;
  logic                  full_q, empty_q, afull_q, aempty_q;
  logic                  pop_valid_q;
  logic                  err_ovf_q, err_unf_q;
  logic                  push_ok, pop_ok;

  // Pop is checked first: a push into a full FIFO is fine if a pop frees a slot.
  always_comb begin
    pop_ok  = pop & ~empty_q;
    push_ok = push & (~full_q | pop_ok);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrOne;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      pop_valid_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      // Flags come from the next count so they line up with count itself.
      full_q      <= (count_d == DepthCnt);
      empty_q     <= (count_d == '0);
      afull_q     <= (count_d >= AfullTh);
      aempty_q    <= (count_d <= AemptyTh);
      pop_valid_q <= pop_ok;
      if (push & ~push_ok) err_ovf_q <= 1'b1;
      if (pop & ~pop_ok)   err_unf_q <= 1'b1;
    end
  end

  // RAM strobes are gated by reset so nothing is written or read while in reset.
  always_comb begin
    wr_enb        = push_ok & reset;
    wr_addr       = wr_ptr_q;
    data_in       = data_push;
    rd_enb        = pop_ok & reset;
    rd_addr       = rd_ptr_q;
    pop_data      = data_out;
    pop_valid     = pop_valid_q;
    full          = full_q;
    empty         = empty_q;
    almost_full   = afull_q;
    almost_empty  = aempty_q;
    count         = count_q;
    err_overflow  = err_ovf_q;
    err_underflow = err_unf_q;
  end

endmodule
